// File: rtl/regfile_wb_sequencer_if.sv
// Writeback, issue/decode and register-file write-port signals of the writeback sequencer.
// The slave side is the sequencer; the master side is the surrounding core (or a bench).
interface regfile_wb_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_rsd;
    logic [DATA_W-1:0] wb0_data;
    logic              wb0_ready;

    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_rsd;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rsd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;

    logic [ADDR_W-1:0] rf_rsd;
    logic [DATA_W-1:0] rf_data;
    logic              rf_we;

    modport slave (
        input  wb0_valid, wb0_rsd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rsd, wb1_data,
        output wb1_ready,
        input  iss_valid, iss_rsd, rs1, rs2,
        output rs1_busy, rs2_busy,
        output rf_rsd, rf_data, rf_we
    );

    modport master (
        output wb0_valid, wb0_rsd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rsd, wb1_data,
        input  wb1_ready,
        output iss_valid, iss_rsd, rs1, rs2,
        input  rs1_busy, rs2_busy,
        input  rf_rsd, rf_data, rf_we
    );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Round-robin writeback arbiter driving the register file's single write port with a
// setup-then-strobe sequence, plus a busy scoreboard for RAW-hazard stalls in decode.
module regfile_wb_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    regfile_wb_sequencer_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0] rf_rsd_q, rf_rsd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              rf_we_q, rf_we_d;
    logic              grant0, grant1;

    // Grants only in IDLE; on contention rr_ptr picks the winner, so at most one is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = bus.wb0_valid && (!bus.wb1_valid || !rr_ptr_q);
            grant1 = bus.wb1_valid && (!bus.wb0_valid ||  rr_ptr_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        rf_rsd_d  = rf_rsd_q;
        rf_data_d = rf_data_q;
        rf_we_d   = rf_we_q;

        case (state_q)
            IDLE: begin
                if (grant0) begin
                    rr_ptr_d = 1'b1;
                    if (bus.wb0_rsd != '0) begin
                        rf_rsd_d  = bus.wb0_rsd;
                        rf_data_d = bus.wb0_data;
                        state_d   = SETUP;
                    end
                end else if (grant1) begin
                    rr_ptr_d = 1'b0;
                    if (bus.wb1_rsd != '0) begin
                        rf_rsd_d  = bus.wb1_rsd;
                        rf_data_d = bus.wb1_data;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                rf_we_d = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                rf_we_d          = 1'b0;
                busy_d[rf_rsd_q] = 1'b0;
                state_d          = IDLE;
            end
            default: begin
                rf_we_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Applied after the STROBE clear so a same-edge issue keeps the bit set.
        if (bus.iss_valid && (bus.iss_rsd != '0)) begin
            busy_d[bus.iss_rsd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            busy_q    <= '0;
            rf_rsd_q  <= '0;
            rf_data_q <= '0;
            rf_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            rf_rsd_q  <= rf_rsd_d;
            rf_data_q <= rf_data_d;
            rf_we_q   <= rf_we_d;
        end
    end

    assign bus.wb0_ready = grant0;
    assign bus.wb1_ready = grant1;
    assign bus.rs1_busy  = busy_q[bus.rs1];
    assign bus.rs2_busy  = busy_q[bus.rs2];
    assign bus.rf_rsd    = rf_rsd_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.rf_we     = rf_we_q;
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer: reset, single write timing, round-robin order,
// x0 discard, set-over-clear in the scoreboard, and reset abort mid-sequence.
module tb_regfile_wb_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    regfile_wb_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1;
        bus.wb0_valid = 1'b0; bus.wb0_rsd = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_rsd = '0; bus.wb1_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rsd = '0;
        bus.rs1 = '0; bus.rs2 = '0;

        // 1) reset
        cyc();
        cyc();
        clr = 1'b0;
        bus.rs1 = 5'd5; bus.rs2 = 5'd9;
        #1;
        check_eq("rst_rf_we",    bus.rf_we,     0);
        check_eq("rst_rf_rsd",   bus.rf_rsd,    0);
        check_eq("rst_rf_data",  bus.rf_data,   0);
        check_eq("rst_rs1_busy", bus.rs1_busy,  0);
        check_eq("rst_rs2_busy", bus.rs2_busy,  0);
        check_eq("rst_wb0_rdy",  bus.wb0_ready, 0);
        check_eq("rst_wb1_rdy",  bus.wb1_ready, 0);

        // issuing x0 never marks it busy
        bus.iss_valid = 1'b1; bus.iss_rsd = 5'd0;
        cyc();
        bus.iss_valid = 1'b0; bus.rs1 = 5'd0;
        #1;
        check_eq("x0_never_busy", bus.rs1_busy, 0);

        // 2) single ALU write to x5
        bus.rs1 = 5'd5;
        bus.iss_valid = 1'b1; bus.iss_rsd = 5'd5;
        #1;
        check_eq("no_bypass", bus.rs1_busy, 0);
        cyc();
        bus.iss_valid = 1'b0;
        #1;
        check_eq("x5_busy_set", bus.rs1_busy, 1);
        bus.wb0_valid = 1'b1; bus.wb0_rsd = 5'd5; bus.wb0_data = 32'hDEADBEEF;
        #1;
        check_eq("x5_wb0_rdy", bus.wb0_ready, 1);
        check_eq("x5_wb1_rdy", bus.wb1_ready, 0);
        cyc();
        bus.wb0_valid = 1'b0;
        #1;
        check_eq("x5_setup_rsd",  bus.rf_rsd,  5);
        check_eq("x5_setup_data", bus.rf_data, 32'hDEADBEEF);
        check_eq("x5_setup_we",   bus.rf_we,   0);
        cyc();
        check_eq("x5_strobe_we",   bus.rf_we,    1);
        check_eq("x5_strobe_busy", bus.rs1_busy, 1);
        cyc();
        check_eq("x5_done_we",   bus.rf_we,    0);
        check_eq("x5_done_busy", bus.rs1_busy, 0);

        // 3) both requesters valid from reset
        clr = 1'b1;
        bus.wb0_valid = 1'b1; bus.wb0_rsd = 5'd1; bus.wb0_data = 32'h11111111;
        bus.wb1_valid = 1'b1; bus.wb1_rsd = 5'd2; bus.wb1_data = 32'h22222222;
        cyc();
        clr = 1'b0;
        #1;
        check_eq("rr_a_wb0_rdy", bus.wb0_ready, 1);
        check_eq("rr_a_wb1_rdy", bus.wb1_ready, 0);
        cyc();
        bus.wb0_valid = 1'b0;
        #1;
        check_eq("rr_a_setup_wb1_rdy", bus.wb1_ready, 0);
        check_eq("rr_a_rsd", bus.rf_rsd, 1);
        cyc();
        check_eq("rr_a_we",     bus.rf_we,     1);
        check_eq("rr_a_we_rsd", bus.rf_rsd,    1);
        check_eq("rr_a_strobe_wb1_rdy", bus.wb1_ready, 0);
        cyc();
        check_eq("rr_b_wb1_rdy", bus.wb1_ready, 1);
        check_eq("rr_b_idle_we", bus.rf_we,     0);
        cyc();
        bus.wb1_valid = 1'b0;
        #1;
        check_eq("rr_b_rsd",  bus.rf_rsd,  2);
        check_eq("rr_b_data", bus.rf_data, 32'h22222222);
        cyc();
        check_eq("rr_b_we",     bus.rf_we,  1);
        check_eq("rr_b_we_rsd", bus.rf_rsd, 2);
        cyc();
        bus.wb0_valid = 1'b1; bus.wb0_rsd = 5'd3; bus.wb0_data = 32'h33333333;
        bus.wb1_valid = 1'b1; bus.wb1_rsd = 5'd4; bus.wb1_data = 32'h44444444;
        #1;
        check_eq("rr_c_wb0_rdy", bus.wb0_ready, 1);
        check_eq("rr_c_wb1_rdy", bus.wb1_ready, 0);
        cyc();
        bus.wb0_valid = 1'b0;
        cyc();
        check_eq("rr_c_we_rsd", bus.rf_rsd, 3);
        cyc();
        check_eq("rr_d_wb1_rdy", bus.wb1_ready, 1);
        cyc();
        bus.wb1_valid = 1'b0;
        cyc();
        check_eq("rr_d_we_rsd", bus.rf_rsd, 4);
        cyc();

        // 4) load write to x0 is accepted and dropped
        bus.wb1_valid = 1'b1; bus.wb1_rsd = 5'd0; bus.wb1_data = 32'h00001234;
        #1;
        check_eq("x0_wb1_rdy", bus.wb1_ready, 1);
        cyc();
        bus.wb1_valid = 1'b0;
        #1;
        check_eq("x0_we_0",   bus.rf_we,   0);
        check_eq("x0_data",   bus.rf_data, 32'h44444444);
        cyc();
        check_eq("x0_we_1",   bus.rf_we,   0);
        cyc();
        check_eq("x0_we_2",   bus.rf_we,   0);

        // 5) re-issue of x7 on the strobe edge keeps it busy
        bus.rs2 = 5'd7;
        bus.iss_valid = 1'b1; bus.iss_rsd = 5'd7;
        cyc();
        bus.iss_valid = 1'b0;
        #1;
        check_eq("x7_busy_set", bus.rs2_busy, 1);
        bus.wb0_valid = 1'b1; bus.wb0_rsd = 5'd7; bus.wb0_data = 32'h77777777;
        #1;
        check_eq("x7_wb0_rdy_idle", bus.wb0_ready, 1);
        cyc();
        bus.wb0_valid = 1'b0;
        cyc();
        check_eq("x7_strobe_we", bus.rf_we, 1);
        bus.iss_valid = 1'b1; bus.iss_rsd = 5'd7;
        cyc();
        bus.iss_valid = 1'b0;
        #1;
        check_eq("x7_set_wins", bus.rs2_busy, 1);
        check_eq("x7_done_we",  bus.rf_we,    0);

        // 6) reset during SETUP aborts the write
        bus.rs1 = 5'd9;
        bus.iss_valid = 1'b1; bus.iss_rsd = 5'd9;
        cyc();
        bus.iss_valid = 1'b0;
        #1;
        check_eq("x9_busy_set", bus.rs1_busy, 1);
        bus.wb0_valid = 1'b1; bus.wb0_rsd = 5'd9; bus.wb0_data = 32'h99999999;
        #1;
        check_eq("x9_wb0_rdy", bus.wb0_ready, 1);
        cyc();
        bus.wb0_valid = 1'b0;
        #1;
        check_eq("x9_setup_rsd", bus.rf_rsd, 9);
        check_eq("x9_setup_we",  bus.rf_we,  0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        #1;
        check_eq("abort_we",       bus.rf_we,    0);
        check_eq("abort_busy",     bus.rs1_busy, 0);
        check_eq("abort_busy7",    bus.rs2_busy, 0);
        check_eq("abort_rsd",      bus.rf_rsd,   0);
        cyc();
        check_eq("abort_we_later", bus.rf_we,    0);
        bus.wb1_valid = 1'b1; bus.wb1_rsd = 5'd10; bus.wb1_data = 32'h000000AA;
        #1;
        check_eq("post_wb1_rdy", bus.wb1_ready, 1);
        cyc();
        bus.wb1_valid = 1'b0;
        cyc();
        check_eq("post_we",   bus.rf_we,   1);
        check_eq("post_rsd",  bus.rf_rsd,  10);
        check_eq("post_data", bus.rf_data, 32'h000000AA);
        cyc();
        check_eq("post_we_off", bus.rf_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
